trap_monitor: RTL
=================

# trap_monitor

Parametrised trap/redirect controller for the processor front end. It arbitrates fetch redirects among a branch-miss correction, NUM_SRC prioritised trap sources and an ordinary jump, and tracks the two-bit privilege mode. Trap requests are held until taken; no request is dropped. After each trap the block enforces a flush hold-off window. It sits between the decode/execute fault detectors and the PC-select logic.

## Interface
- NUM_SRC, 4: number of trap sources; index 0 has the highest priority.
- PC_W, 16: PC and vector width.
- VEC_BASE, 16'h0000: handler address of source 0.
- VEC_STRIDE, 16'h0030: address spacing between consecutive handlers.
- MASKABLE, 4'b1000: per-source bit; when set, the source is blocked while mode[1]=1.
- FLUSH_CYC, 3: hold-off cycles after a trap redirect (≥1).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- miss  in  1  branch mispredict; requests a redirect to branch_pc.
- jump  in  1  taken jump; requests a redirect to new_pc.
- new_pc, branch_pc  in  PC_W  redirect targets.
- mode_set  in  2  mode command: 01 → 00; 10 → 01; 11 → return; 00 → hold.
- src_req  in  NUM_SRC  level trap requests.
- j  out  1  redirect valid (combinational).
- j_r  out  PC_W  redirect target; 0 when j=0.
- store_current  out  1  save the current PC as the return PC (combinational).
- mode  out  2  privilege mode register.
- cause  out  $clog2(NUM_SRC)  index of the last trap taken (registered).
- busy  out  1  high while in the FLUSH state.

## Operation
- pend[i] is set at any edge where src_req[i]=1. It clears only at the edge where trap i is taken. A new request in the same cycle as the take re-sets the bit (set wins).
- elig[i] = pend[i] & ~(MASKABLE[i] & mode[1]). sel = the lowest-index eligible source.
- FSM states:
  - RUN: a trap fires when state=RUN, |elig and ~miss.
  - FLUSH: entered on a trap; a counter loads FLUSH_CYC-1 and decrements each cycle; returns to RUN after the cycle in which the counter is 0. No trap fires in FLUSH; pend continues to accumulate.
- Redirect priority (combinational), highest first:
  1. miss: j=1, j_r=branch_pc, store_current=0.
  2. Trap fires: j=1, j_r=VEC_BASE+sel*VEC_STRIDE, truncated to PC_W bits (wraps modulo 2^PC_W), store_current=1.
  3. jump: j=1, j_r=new_pc, store_current=0.
  4. None of the above: j=0, j_r=0, store_current=0.
- On the edge where a trap fires:
  - mode ← {1, mode[0]};
  - saved_mode ← mode (only with TRAP_SAVE_MODE_EN);
  - cause ← sel;
  - pend[sel] ← 0;
  - state ← FLUSH.
- Trap entry overrides mode_set in the same cycle. Otherwise mode_set applies at the edge.
- A miss in the same cycle as an eligible trap: miss wins and the trap stays pending. It fires in the next cycle if still eligible.

## Timing
- src_req at edge N → pend at N+1 → j/j_r valid in cycle N+1 (one-cycle latency). mode, cause and busy update at edge N+2.
- Minimum spacing between two trap redirects: FLUSH_CYC+1 cycles.
- Reset values (rst_n=0 sampled at an edge):
  - mode=2'b11, saved_mode=2'b11;
  - pend=0, cause=0;
  - state=RUN, counter=0, busy=0;
  - j=0, j_r=0, store_current=0 (as long as miss/jump are low).
- Reset mid-FLUSH aborts the window. Pending requests are discarded.

## Configuration
- TRAP_SAVE_MODE_EN defined: saved_mode is implemented; mode_set=11 restores mode ← saved_mode.
- TRAP_SAVE_MODE_EN undefined: no saved_mode register; mode_set=11 gives mode ← {0, mode[0]}.

## Test plan
- Reset release, mode_set=01, then src_req=4'b0001 for 1 cycle → next cycle: j=1, j_r=16'h0000, store_current=1. After the edge: mode=2'b10, cause=0, busy=1 for 3 cycles.
- src_req=4'b0110 in one cycle, mode=00 → first trap j_r=16'h0030 (source 1). Source 2 fires 4 cycles later with j_r=16'h0060.
- mode=2'b10, src_req=4'b1000 → no trap while mode[1]=1. After mode_set=11 (macro on, saved_mode=00) → mode=00, then j_r=16'h0090 on the following cycle.
- miss=1, branch_pc=16'h1234 in the same cycle as a pending source 0 → j_r=16'h1234, store_current=0; next cycle j_r=16'h0000, store_current=1.
- jump=1, new_pc=16'h0400, no traps → j=1, j_r=16'h0400. rst_n=0 during FLUSH with pend≠0 → busy=0, no trap after reset release.
- Macro off: enter a trap from mode 01, then mode_set=11 → mode=2'b01 ({0, mode[0]}).

Source files
------------

// File: rtl/trap_monitor.sv
// Trap/redirect controller: arbitrates miss, prioritised trap sources and jump; tracks privilege mode.
// Optional TRAP_SAVE_MODE_EN: keeps the pre-trap mode so that mode_set=11 can restore it.

module trap_monitor_src (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic take,
  input  logic blk,
  output logic pend,
  output logic elig
);
  // A request arriving in the same cycle as the take re-arms the bit.
  always_ff @(posedge clk) begin
    if (!rst_n)     pend <= 1'b0;
    else if (req)   pend <= 1'b1;
    else if (take)  pend <= 1'b0;
  end

  assign elig = pend & ~blk;
endmodule

module trap_monitor #(
  parameter int                NUM_SRC    = 4,
  parameter int                PC_W       = 16,
  parameter logic [PC_W-1:0]   VEC_BASE   = 16'h0000,
  parameter logic [PC_W-1:0]   VEC_STRIDE = 16'h0030,
  parameter logic [NUM_SRC-1:0] MASKABLE  = 4'b1000,
  parameter int                FLUSH_CYC  = 3,
  localparam int               CW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               miss,
  input  logic               jump,
  input  logic [PC_W-1:0]    new_pc,
  input  logic [PC_W-1:0]    branch_pc,
  input  logic [1:0]         mode_set,
  input  logic [NUM_SRC-1:0] src_req,
  output logic               j,
  output logic [PC_W-1:0]    j_r,
  output logic               store_current,
  output logic [1:0]         mode,
  output logic [CW-1:0]      cause,
  output logic               busy
);
  localparam int NW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state, state_nx;
  logic [NW-1:0]      cnt, cnt_nx;
  logic [NUM_SRC-1:0] pend, elig, take, blk;
  logic [CW-1:0]      sel;
  logic               any, fire;
  logic [PC_W-1:0]    vec;

  assign blk = MASKABLE & {NUM_SRC{mode[1]}};

  trap_monitor_src u_src [NUM_SRC-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (src_req),
    .take (take),
    .blk  (blk),
    .pend (pend),
    .elig (elig)
  );

  // Lowest eligible index wins: scan from the top so the last hit is the smallest.
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (elig[i]) sel = CW'(i);
  end

  assign any  = |elig;
  assign fire = (state == RUN) & any & ~miss;
  assign take = fire ? (NUM_SRC'(1) << sel) : '0;
  assign vec  = VEC_BASE + PC_W'(sel) * VEC_STRIDE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      RUN: if (fire) begin
        state_nx = FLUSH;
        cnt_nx   = NW'(FLUSH_CYC - 1);
      end
      FLUSH: begin
        if (cnt == '0) state_nx = RUN;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    j             = 1'b0;
    j_r           = '0;
    store_current = 1'b0;
    busy          = (state == FLUSH);
    if (miss) begin
      j   = 1'b1;
      j_r = branch_pc;
    end else if (fire) begin
      j             = 1'b1;
      j_r           = vec;
      store_current = 1'b1;
    end else if (jump) begin
      j   = 1'b1;
      j_r = new_pc;
    end
  end

`ifdef TRAP_SAVE_MODE_EN
  logic [1:0] saved_mode;

  always_ff @(posedge clk) begin
    if (!rst_n)    saved_mode <= 2'b11;
    else if (fire) saved_mode <= mode;
  end
`endif

  // Trap entry takes precedence over any mode command in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode  <= 2'b11;
      cause <= '0;
    end else if (fire) begin
      mode  <= {1'b1, mode[0]};
      cause <= sel;
    end else begin
      case (mode_set)
        2'b01: mode <= 2'b00;
        2'b10: mode <= 2'b01;
`ifdef TRAP_SAVE_MODE_EN
        2'b11: mode <= saved_mode;
`else
        2'b11: mode <= {1'b0, mode[0]};
`endif
        default: ;
      endcase
    end
  end
endmodule
